bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits directly upstream of the APB BCD subtractor peripheral: it turns a
//   binary value into the 3-digit (12-bit) packed BCD operand that the
//   subtractor's 12-bit operand registers hold. Values above 999 saturate
//   to 12'h999 and raise an overflow flag.
// PARAMETERS
//   BIN_W     10   width of binary input; legal range 4..16
//   BCD_MAX   999  saturation limit, decimal; fixed by the 3-digit output
// PORTS
//   PCLK      in   1      sole clock, all logic on posedge
//   PRESET    in   1      synchronous reset, active-high
//   start     in   1      conversion request, sampled only in IDLE
//   bin_in    in   BIN_W  unsigned binary value, captured with start
//   busy      out  1      high while a conversion is in progress
//   done      out  1      one-cycle pulse: bcd_out/overflow updated
//   bcd_out   out  12     packed BCD result {hundreds,tens,units}
//   overflow  out  1      last captured bin_in was > 999
// BEHAVIOUR
//   Clock/reset: single clock PCLK; reset is synchronous, active-high (PRESET).
//   Reset values: busy=0, done=0, bcd_out=12'h000, overflow=0, state=IDLE,
//     shift count=0, internal scratch cleared.
//   Reset mid-conversion: abort; next cycle is IDLE; no done pulse; bcd_out
//     and overflow read 0.
//   FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: busy=0. On start=1 at edge k: capture bin_in into binary shift reg,
//     clear 20-bit (5-digit) BCD scratch, count=0, go SHIFT, busy=1 after k.
//   SHIFT: each cycle, first add 3 to every scratch digit >= 5, then shift
//     {scratch,binreg} left by 1. count increments. After BIN_W iterations
//     (count==BIN_W-1 at the edge) go DONE. busy=1 throughout SHIFT.
//   DONE: for exactly one cycle, busy=0 and done=1. On entry, bcd_out and
//     overflow are updated. Next state is IDLE.
//   Latency: start accepted at edge k -> done=1 and new bcd_out valid in the
//     cycle after edge k+BIN_W+1 (11 cycles for BIN_W=10). Throughput: one
//     conversion per BIN_W+2 cycles.
//   Saturation: overflow=1 if scratch digits 4..3 (thousands and above) are
//     nonzero. Then bcd_out=12'h999. Otherwise bcd_out=scratch[11:0] and
//     overflow=0. For BIN_W<=9, overflow is constant 0.
//   start while busy or in DONE: ignored, with no effect on the current
//     conversion and no queueing. bin_in is don't-care outside the capture
//     edge.
//   bcd_out and overflow hold their value between done pulses. They are
//     never partially updated, so they are safe to sample while busy.
//   No combinational path from any input to any output. All outputs are
//     registered.
// TESTING
//   1. PRESET then start, bin_in=0 -> done pulse 11 cycles later,
//      bcd_out=12'h000, overflow=0; busy high for exactly 10 cycles.
//   2. bin_in=587 -> bcd_out=12'h587, overflow=0; bin_in=999 ->
//      bcd_out=12'h999, overflow=0.
//   3. bin_in=1000 and bin_in=1023 -> bcd_out=12'h999, overflow=1 for both.
//   4. Start with bin_in=123; at cycle 4 pulse start with bin_in=456 ->
//      single done, bcd_out=12'h123. Start the cycle after done with 456 ->
//      accepted, bcd_out=12'h456.
//   5. Load result 12'h321. Start 777, assert PRESET at cycle 5 for 1 cycle ->
//      no done, bcd_out=0, busy=0. Next start 42 -> bcd_out=12'h042.
//   6. Exhaustive sweep 0..1023 against reference model; check the latency
//      of every done and hold of bcd_out between pulses.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// +--------------------------------------------------------------------+
// | Module : bin_to_bcd_seq_if                                          |
// | Brief  : Request/result bundle for the sequential binary-to-BCD     |
// |          converter.                                                 |
// | Rev    : 1.0  initial release                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface bin_to_bcd_seq_if #(
  parameter int BIN_W = 10
);
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [11:0]      bcd_out;
  logic             overflow;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// +--------------------------------------------------------------------+
// | Module : bin_to_bcd_seq                                             |
// | Brief  : Shift-and-add-3 binary to 3-digit packed BCD, one bit per  |
// |          clock, saturating to 999 with an overflow flag.            |
// | Rev    : 1.0  initial release                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module bin_to_bcd_seq #(
  parameter int BIN_W   = 10,
  parameter int BCD_MAX = 999
) (
  input  wire logic         PCLK,
  input  wire logic         PRESET,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int               c_CNT_W  = $clog2(BIN_W);
  localparam int               c_DIGITS = 5;
  localparam int               c_SCR_W  = 4 * c_DIGITS;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);
  localparam logic [11:0]      c_SAT    = {4'(BCD_MAX / 100),
                                           4'((BCD_MAX / 10) % 10),
                                           4'(BCD_MAX % 10)};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIN_W-1:0]     r_bin;
  logic [c_SCR_W-1:0]   r_scratch;
  logic [c_SCR_W-1:0]   w_adj;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [11:0]          r_bcd;
  logic                 r_ovf;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_over;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == c_LAST);

  // Correct every digit before the shift so it carries properly into the next digit.
  for (genvar g = 0; g < c_DIGITS; g++) begin : g_digit
    assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                             (r_scratch[4*g +: 4] + 4'd3) : r_scratch[4*g +: 4];
  end

  // Narrow inputs can never exceed 511, so no thousands digit can appear.
  if (BIN_W <= 9) begin : g_no_ovf
    assign w_over = 1'b0;
  end else begin : g_ovf
    assign w_over = |r_scratch[c_SCR_W-1:12];
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)   w_state_nxt = S_DONE;
      S_DONE:                w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= 12'h000;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bin     <= bus.bin_in;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          {r_scratch, r_bin} <= {w_adj[c_SCR_W-2:0], r_bin, 1'b0};
          r_cnt              <= r_cnt + c_CNT_W'(1);
          if (w_last) begin
            r_busy <= 1'b0;
          end
        end
        S_DONE: begin
          // Result and flag change together so a mid-conversion read is never torn.
          r_done <= 1'b1;
          r_ovf  <= w_over;
          r_bcd  <= w_over ? c_SAT : r_scratch[11:0];
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// +--------------------------------------------------------------------+
// | Module : tb_bin_to_bcd_seq                                          |
// | Brief  : Scoreboard bench for bin_to_bcd_seq.                       |
// | Rev    : 1.0  initial release                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_bin_to_bcd_seq;

  localparam int BIN_W = 10;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic PCLK = 1'b0;
  logic PRESET;

  always #5 PCLK = ~PCLK;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .BCD_MAX(999)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rst_q = 1'b0;
  logic [11:0] last_bcd = 12'h000;
  logic        last_ovf = 1'b0;
  int          busy_run = 0;
  int          busy_len = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int v, input int k);
    exp_t e;
    if (v > 999) begin
      e.bcd = 12'h999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    e.cyc = k + BIN_W + 1;
    return e;
  endfunction

  always @(posedge PCLK) begin
    cyc++;
    rst_q = PRESET;
  end

  // Observe half a cycle after each edge: pop on done, otherwise outputs must hold.
  always @(negedge PCLK) begin
    exp_t e;
    if (rst_q) begin
      check("rst_bcd_out", 32'(bus.bcd_out), 32'h0);
      check("rst_overflow", 32'(bus.overflow), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      sb.delete();
      last_bcd = 12'h000;
      last_ovf = 1'b0;
      busy_run = 0;
      busy_len = 0;
    end else begin
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        busy_len = busy_run;
        busy_run = 0;
      end
      if (bus.done) begin
        check("done_busy_exclusive", 32'(bus.busy), 32'h0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
          check("overflow", 32'(bus.overflow), 32'(e.ovf));
          check("latency_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_len", 32'(busy_len), 32'(BIN_W));
        end
        busy_len = 0;
        last_bcd = bus.bcd_out;
        last_ovf = bus.overflow;
      end else begin
        check("hold_bcd_out", 32'(bus.bcd_out), 32'(last_bcd));
        check("hold_overflow", 32'(bus.overflow), 32'(last_ovf));
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  // Called 2 units after an edge; the next edge is the capture edge.
  task automatic launch(input int v, input bit accept);
    bus.start  = 1'b1;
    bus.bin_in = BIN_W'(v);
    tick();
    bus.start  = 1'b0;
    bus.bin_in = BIN_W'($urandom);
    if (accept) sb.push_back(model(v, cyc));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sb.size() == 0) return;
    end
    check("done_timeout", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET     = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) tick();
    PRESET = 1'b0;
    tick();

    // Zero, mid-range and top-of-range values.
    launch(0, 1'b1);    wait_done();
    launch(587, 1'b1);  wait_done();
    launch(999, 1'b1);  wait_done();
    launch(1000, 1'b1); wait_done();
    launch(1023, 1'b1); wait_done();

    // A start pulse while busy must be ignored.
    launch(123, 1'b1);
    repeat (3) tick();
    launch(456, 1'b0);
    wait_done();
    check("t4_bcd_after_ignored", 32'(bus.bcd_out), 32'h123);
    launch(456, 1'b1);  wait_done();

    // A start sampled while in the DONE state must be ignored too.
    launch(300, 1'b1);
    repeat (BIN_W) tick();
    launch(5, 1'b0);
    wait_done();
    repeat (BIN_W + 4) tick();
    check("t4b_bcd_done_start", 32'(bus.bcd_out), 32'h300);

    // Reset in the middle of a conversion aborts it.
    launch(321, 1'b1);  wait_done();
    launch(777, 1'b1);
    repeat (4) tick();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    repeat (BIN_W + 5) tick();
    check("t5_busy", 32'(bus.busy), 32'h0);
    check("t5_bcd_out", 32'(bus.bcd_out), 32'h0);
    check("t5_overflow", 32'(bus.overflow), 32'h0);
    launch(42, 1'b1);   wait_done();
    check("t5_bcd_after", 32'(bus.bcd_out), 32'h042);

    for (int v = 0; v < (1 << BIN_W); v++) begin
      launch(v, 1'b1);
      wait_done();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
